acq_group_sequencer: RTL and testbench

- Sequences one acquisition group through the trigger → FIFO_in/Power_Spec_Cal → FIFO_Buffer → upload chain.
- Arms capture and counts accumulated pulses against the configured total.
- Asserts is_first_pls for the first pulse of a group so the buffers overwrite rather than accumulate.
- Stops capture, requests an upload, then either re-arms (continuous mode) or returns to idle.

---
 rtl/acq_group_sequencer.sv | 149 ++++++++++++++
 tb/tb_acq_group_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_group_sequencer.sv
// rtl/acq_group_sequencer.sv - acquisition group sequencer: trigger, accumulate, upload, re-arm
// Counts accumulated pulses per group and hands each finished group to the upload switcher.
module acq_group_sequencer #(
   parameter int CNT_W         = 16,
   parameter int CMD_START_BIT = 0,
   parameter int CMD_CONT_BIT  = 1,
   parameter int CMD_ABORT_BIT = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [15:0]      cmd_i,
   input  logic [CNT_W-1:0] n_acc_pulses_i,
   input  logic             trigger_i,
   input  logic             pulse_done_i,
   input  logic             upload_ack_i,
   input  logic             upload_done_i,
   output logic             capture_en_o,
   output logic             pulse_start_o,
   output logic             is_first_pls_o,
   output logic             upload_req_o,
   output logic [CNT_W-1:0] pulse_count_o,
   output logic [CNT_W-1:0] group_count_o,
   output logic [CNT_W-1:0] missed_trig_o,
   output logic             cfg_err_o,
   output logic             busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TRIG,
      S_PROC,
      S_UPLOAD_REQ,
      S_UPLOAD_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_n;
   logic             start_prev;
   logic             start_rise, abort, cont, group_done;
   logic [CNT_W-1:0] n_acc, n_acc_n;
   logic [CNT_W-1:0] pulse_count_n, group_count_n, missed_trig_n;
   logic             cfg_err_n, pulse_start_n;
   logic             unused_cmd_bits;

   assign start_rise = cmd_i[CMD_START_BIT] & ~start_prev;
   assign abort      = cmd_i[CMD_ABORT_BIT];
   assign cont       = cmd_i[CMD_CONT_BIT];
   // Only three command bits belong to this block; the rest are decoded elsewhere.
   assign unused_cmd_bits = ^cmd_i;

   // A done arriving together with the ack finishes the group as if it came one cycle later.
   assign group_done = upload_done_i &
                       ((state == S_UPLOAD_WAIT) || ((state == S_UPLOAD_REQ) && upload_ack_i));

   always_comb begin
      state_n       = state;
      n_acc_n       = n_acc;
      pulse_count_n = pulse_count_o;
      group_count_n = group_count_o;
      missed_trig_n = missed_trig_o;
      cfg_err_n     = cfg_err_o;
      pulse_start_n = 1'b0;
      if (abort) begin
         state_n       = S_IDLE;
         pulse_count_n = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_rise) begin
                  if (n_acc_pulses_i != '0) begin
                     n_acc_n       = n_acc_pulses_i;
                     pulse_count_n = '0;
                     cfg_err_n     = 1'b0;
                     state_n       = S_WAIT_TRIG;
                  end else begin
                     cfg_err_n = 1'b1;
                  end
               end
            end
            S_WAIT_TRIG: begin
               if (trigger_i) begin
                  pulse_start_n = 1'b1;
                  state_n       = S_PROC;
               end
            end
            S_PROC: begin
               if (trigger_i && (missed_trig_o != CNT_MAX)) begin
                  missed_trig_n = missed_trig_o + CNT_ONE;
               end
               if (pulse_done_i) begin
                  pulse_count_n = pulse_count_o + CNT_ONE;
                  state_n = (pulse_count_n == n_acc) ? S_UPLOAD_REQ : S_WAIT_TRIG;
               end
            end
            S_UPLOAD_REQ: begin
               if (upload_ack_i) begin
                  state_n = S_UPLOAD_WAIT;
               end
            end
            S_UPLOAD_WAIT: ;
            default: state_n = S_IDLE;
         endcase
         if (group_done) begin
            group_count_n = group_count_o + CNT_ONE;
            if (cont) begin
               pulse_count_n = '0;
               state_n       = S_WAIT_TRIG;
            end else begin
               state_n = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= S_IDLE;
         start_prev     <= 1'b0;
         n_acc          <= '0;
         capture_en_o   <= 1'b0;
         pulse_start_o  <= 1'b0;
         is_first_pls_o <= 1'b0;
         upload_req_o   <= 1'b0;
         pulse_count_o  <= '0;
         group_count_o  <= '0;
         missed_trig_o  <= '0;
         cfg_err_o      <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         state          <= state_n;
         start_prev     <= cmd_i[CMD_START_BIT];
         n_acc          <= n_acc_n;
         capture_en_o   <= (state_n == S_WAIT_TRIG) || (state_n == S_PROC);
         pulse_start_o  <= pulse_start_n;
         // Derived from the registered count, so it trails pulse_count_o by one cycle.
         is_first_pls_o <= ((state == S_WAIT_TRIG) || (state == S_PROC)) &&
                           (pulse_count_o == '0);
         upload_req_o   <= (state_n == S_UPLOAD_REQ);
         pulse_count_o  <= pulse_count_n;
         group_count_o  <= group_count_n;
         missed_trig_o  <= missed_trig_n;
         cfg_err_o      <= cfg_err_n;
         busy_o         <= (state_n != S_IDLE);
      end
   end

endmodule

// File: tb/tb_acq_group_sequencer.sv
// tb/tb_acq_group_sequencer.sv - self-checking bench for acq_group_sequencer
// Directed steps plus randomized groups checked against a transaction-level model.
module tb_acq_group_sequencer;

   localparam int CNT_W = 16;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic [15:0]      cmd_i;
   logic [CNT_W-1:0] n_acc_pulses_i;
   logic             trigger_i;
   logic             pulse_done_i;
   logic             upload_ack_i;
   logic             upload_done_i;
   logic             capture_en_o;
   logic             pulse_start_o;
   logic             is_first_pls_o;
   logic             upload_req_o;
   logic [CNT_W-1:0] pulse_count_o;
   logic [CNT_W-1:0] group_count_o;
   logic [CNT_W-1:0] missed_trig_o;
   logic             cfg_err_o;
   logic             busy_o;

   acq_group_sequencer #(.CNT_W(CNT_W)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .cmd_i          (cmd_i),
      .n_acc_pulses_i (n_acc_pulses_i),
      .trigger_i      (trigger_i),
      .pulse_done_i   (pulse_done_i),
      .upload_ack_i   (upload_ack_i),
      .upload_done_i  (upload_done_i),
      .capture_en_o   (capture_en_o),
      .pulse_start_o  (pulse_start_o),
      .is_first_pls_o (is_first_pls_o),
      .upload_req_o   (upload_req_o),
      .pulse_count_o  (pulse_count_o),
      .group_count_o  (group_count_o),
      .missed_trig_o  (missed_trig_o),
      .cfg_err_o      (cfg_err_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;
   int exp_pc, exp_gc, exp_mt;
   bit exp_cfg;

   function automatic int sat_add(input int a, input int b);
      return (a + b > 65535) ? 65535 : a + b;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic start_group(input int n, input bit cont);
      cmd_i = {14'b0, cont, 1'b0};
      step();
      n_acc_pulses_i = 16'(n);
      cmd_i[0] = 1'b1;
      step();
      if (n != 0) begin
         exp_pc  = 0;
         exp_cfg = 1'b0;
      end else begin
         exp_cfg = 1'b1;
      end
      chk("start.busy", 32'(busy_o), 32'(n != 0));
      chk("start.cfg_err", 32'(cfg_err_o), 32'(exp_cfg));
      chk("start.capture", 32'(capture_en_o), 32'(n != 0));
      if (n != 0) chk("start.pulse_count", 32'(pulse_count_o), 0);
   endtask

   task automatic run_pulse(input int idx, input int n, input int gap, input int extra,
                            input bit coincide);
      for (int i = 0; i < gap; i++) step();
      chk("wt.capture", 32'(capture_en_o), 1);
      trigger_i = 1'b1;
      step();
      trigger_i = 1'b0;
      chk("pulse_start", 32'(pulse_start_o), 1);
      chk("is_first", 32'(is_first_pls_o), 32'(idx == 0));
      step();
      chk("pulse_start.width", 32'(pulse_start_o), 0);
      for (int i = 0; i < extra; i++) begin
         trigger_i = 1'b1;
         step();
         trigger_i = 1'b0;
         exp_mt = sat_add(exp_mt, 1);
      end
      pulse_done_i = 1'b1;
      trigger_i    = coincide;
      step();
      pulse_done_i = 1'b0;
      trigger_i    = 1'b0;
      exp_pc++;
      if (coincide) exp_mt = sat_add(exp_mt, 1);
      chk("done.pulse_count", 32'(pulse_count_o), 32'(exp_pc));
      chk("done.missed", 32'(missed_trig_o), 32'(exp_mt));
      chk("done.upload_req", 32'(upload_req_o), 32'(exp_pc == n));
      chk("done.capture", 32'(capture_en_o), 32'(exp_pc != n));
   endtask

   task automatic upload(input bit cont, input int ack_dly, input int done_dly, input bit together);
      for (int i = 0; i < ack_dly; i++) step();
      chk("ureq.level", 32'(upload_req_o), 1);
      chk("ureq.capture", 32'(capture_en_o), 0);
      cmd_i[1]      = cont;
      upload_ack_i  = 1'b1;
      upload_done_i = together;
      step();
      upload_ack_i  = 1'b0;
      upload_done_i = 1'b0;
      if (!together) begin
         chk("ureq.fall", 32'(upload_req_o), 0);
         chk("uwait.busy", 32'(busy_o), 1);
         for (int i = 0; i < done_dly; i++) step();
         upload_done_i = 1'b1;
         step();
         upload_done_i = 1'b0;
      end
      exp_gc = (exp_gc + 1) % 65536;
      if (cont) exp_pc = 0;
      chk("udone.group_count", 32'(group_count_o), 32'(exp_gc));
      chk("udone.pulse_count", 32'(pulse_count_o), 32'(exp_pc));
      chk("udone.busy", 32'(busy_o), 32'(cont));
      chk("udone.capture", 32'(capture_en_o), 32'(cont));
      chk("udone.upload_req", 32'(upload_req_o), 0);
   endtask

   initial begin
      rst_n_i = 1'b0;
      cmd_i = '0;
      n_acc_pulses_i = '0;
      trigger_i = 1'b0;
      pulse_done_i = 1'b0;
      upload_ack_i = 1'b0;
      upload_done_i = 1'b0;
      exp_pc = 0; exp_gc = 0; exp_mt = 0; exp_cfg = 1'b0;
      step();
      step();
      chk("rst.capture", 32'(capture_en_o), 0);
      chk("rst.pulse_start", 32'(pulse_start_o), 0);
      chk("rst.is_first", 32'(is_first_pls_o), 0);
      chk("rst.upload_req", 32'(upload_req_o), 0);
      chk("rst.pulse_count", 32'(pulse_count_o), 0);
      chk("rst.group_count", 32'(group_count_o), 0);
      chk("rst.missed", 32'(missed_trig_o), 0);
      chk("rst.cfg_err", 32'(cfg_err_o), 0);
      chk("rst.busy", 32'(busy_o), 0);
      rst_n_i = 1'b1;
      step();

      // zero-length group flags an error, then a one-pulse group clears it
      start_group(0, 1'b0);
      start_group(1, 1'b0);
      run_pulse(0, 1, 0, 0, 1'b0);
      upload(1'b0, 0, 0, 1'b0);
      chk("n1.group_count", 32'(group_count_o), 1);

      // three-pulse group; a second start mid-group must not re-latch the count
      start_group(3, 1'b0);
      run_pulse(0, 3, 1, 0, 1'b0);
      cmd_i[0] = 1'b0;
      step();
      n_acc_pulses_i = 16'd1;
      cmd_i[0] = 1'b1;
      step();
      chk("midstart.busy", 32'(busy_o), 1);
      chk("midstart.pulse_count", 32'(pulse_count_o), 1);
      run_pulse(1, 3, 0, 0, 1'b0);
      run_pulse(2, 3, 2, 0, 1'b0);
      upload(1'b0, 1, 2, 1'b0);
      chk("n3.pulse_count", 32'(pulse_count_o), 3);

      // continuous mode, three groups of two
      start_group(2, 1'b1);
      for (int g = 0; g < 3; g++) begin
         run_pulse(0, 2, 0, 0, 1'b0);
         run_pulse(1, 2, 1, 0, 1'b0);
         upload(g < 2, g, 1, 1'b0);
      end

      // asynchronous reset in the middle of a pulse
      start_group(2, 1'b0);
      trigger_i = 1'b1;
      step();
      trigger_i = 1'b0;
      rst_n_i = 1'b0;
      #2;
      chk("arst.capture", 32'(capture_en_o), 0);
      chk("arst.pulse_start", 32'(pulse_start_o), 0);
      chk("arst.is_first", 32'(is_first_pls_o), 0);
      chk("arst.upload_req", 32'(upload_req_o), 0);
      chk("arst.pulse_count", 32'(pulse_count_o), 0);
      chk("arst.group_count", 32'(group_count_o), 0);
      chk("arst.missed", 32'(missed_trig_o), 0);
      chk("arst.busy", 32'(busy_o), 0);
      cmd_i = '0;
      step();
      rst_n_i = 1'b1;
      step();
      exp_pc = 0; exp_gc = 0; exp_mt = 0; exp_cfg = 1'b0;
      chk("arst.release_busy", 32'(busy_o), 0);
      for (int i = 0; i < 3; i++) begin
         trigger_i = 1'b1;
         step();
         trigger_i = 1'b0;
         chk("arst.no_pulse_start", 32'(pulse_start_o), 0);
      end

      // four stray triggers, then done and trigger together
      start_group(2, 1'b0);
      run_pulse(0, 2, 0, 4, 1'b1);
      chk("missed.five", 32'(missed_trig_o), 5);
      chk("missed.pc_one", 32'(pulse_count_o), 1);
      run_pulse(1, 2, 0, 0, 1'b0);

      // abort together with ack and done beats both
      cmd_i = 16'h0004;
      upload_ack_i = 1'b1;
      upload_done_i = 1'b1;
      step();
      upload_ack_i = 1'b0;
      upload_done_i = 1'b0;
      exp_pc = 0;
      chk("abort.busy", 32'(busy_o), 0);
      chk("abort.upload_req", 32'(upload_req_o), 0);
      chk("abort.capture", 32'(capture_en_o), 0);
      chk("abort.group_count", 32'(group_count_o), 32'(exp_gc));
      chk("abort.pulse_count", 32'(pulse_count_o), 0);
      cmd_i = 16'h0005;
      step();
      chk("abort.start_ignored", 32'(busy_o), 0);
      cmd_i = 16'h0000;
      step();
      chk("abort.idle", 32'(busy_o), 0);

      // randomized groups
      for (int g = 0; g < 6; g++) begin
         int n;
         int k;
         n = int'($urandom_range(1, 4));
         k = int'($urandom_range(1, 2));
         start_group(n, k > 1);
         for (int j = 0; j < k; j++) begin
            for (int p = 0; p < n; p++) begin
               run_pulse(p, n, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                         1'($urandom_range(0, 1)));
            end
            upload(j < k - 1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
         end
      end

      // missed-trigger counter saturates
      start_group(1, 1'b0);
      trigger_i = 1'b1;
      step();
      for (int i = 0; i < 65540; i++) begin
         step();
         exp_mt = sat_add(exp_mt, 1);
      end
      trigger_i = 1'b0;
      chk("sat.model", 32'(missed_trig_o), 32'(exp_mt));
      chk("sat.max", 32'(missed_trig_o), 32'hFFFF);
      cmd_i = 16'h0004;
      step();
      cmd_i = 16'h0000;
      step();
      chk("sat.abort_idle", 32'(busy_o), 0);
      chk("sat.hold", 32'(missed_trig_o), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
